// File: rtl/rr_arbiter_4.sv
// rtl/rr_arbiter_4.sv - four-way round-robin arbiter; optional hold timeout under ARB_TIMEOUT_EN
module rr_arbiter_4 #(
    parameter int TIMEOUT_CYCLES = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    input  logic       gnt_release,
    output logic       gnt_valid,
    output logic [1:0] gnt_idx,
    output logic       timeout
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t     state, state_next;
    logic [1:0] ptr, ptr_next;
    logic [1:0] idx_q, idx_next;
    logic [1:0] winner;
    logic [1:0] cand;
    logic       found;

    // First requester at or after ptr, wrapping 3 -> 0.
    always_comb begin
        winner = ptr;
        found  = 1'b0;
        cand   = ptr;
        for (int i = 0; i < 4; i++) begin
            cand = ptr + 2'(i);
            if (!found && req[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    logic [7:0] hold_cnt;
    logic       expire;
    logic       to_next;
    logic       timeout_q;

    assign expire  = (hold_cnt == 8'(TIMEOUT_CYCLES - 1));
    assign timeout = timeout_q;

    // Counts completed GRANT cycles; any IDLE cycle clears it before the next grant.
    always_ff @(posedge clk) begin
        if (reset || state != GRANT) begin
            hold_cnt <= '0;
        end else begin
            hold_cnt <= hold_cnt + 8'd1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        idx_next   = idx_q;
`ifdef ARB_TIMEOUT_EN
        to_next    = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (found) begin
                    state_next = GRANT;
                    idx_next   = winner;
                end
            end
            GRANT: begin
                // A voluntary end on the expiry edge takes precedence over the timeout.
                if (gnt_release || !req[idx_q]) begin
                    state_next = IDLE;
                    ptr_next   = idx_q + 2'd1;
`ifdef ARB_TIMEOUT_EN
                end else if (expire) begin
                    state_next = IDLE;
                    ptr_next   = idx_q + 2'd1;
                    to_next    = 1'b1;
`endif
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            ptr   <= 2'b00;
            idx_q <= 2'b00;
`ifdef ARB_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
        end else begin
            state <= state_next;
            ptr   <= ptr_next;
            idx_q <= idx_next;
`ifdef ARB_TIMEOUT_EN
            timeout_q <= to_next;
`endif
        end
    end

    assign gnt_valid = (state == GRANT);
    assign gnt_idx   = idx_q;

endmodule

// File: tb/tb_rr_arbiter_4.sv
// tb/tb_rr_arbiter_4.sv - randomized and directed bench for rr_arbiter_4 against a behavioural model
module tb_rr_arbiter_4;

    localparam int TIMEOUT = 8;
`ifdef ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] req = 4'b0000;
    logic       gnt_release = 1'b0;
    logic       gnt_valid;
    logic [1:0] gnt_idx;
    logic       timeout;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state
    bit m_valid;
    int m_idx;
    int m_ptr;
    bit m_to;
    int m_held;

    rr_arbiter_4 #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .gnt_release (gnt_release),
        .gnt_valid   (gnt_valid),
        .gnt_idx     (gnt_idx),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    task automatic model_edge(input bit rst, input logic [3:0] r, input bit rel);
        if (rst) begin
            m_valid = 0; m_idx = 0; m_ptr = 0; m_to = 0; m_held = 0;
        end else if (!m_valid) begin
            m_to = 0;
            if (r != 4'b0000) begin
                for (int k = 0; k < 4; k++) begin
                    if (r[(m_ptr + k) % 4]) begin
                        m_idx = (m_ptr + k) % 4;
                        break;
                    end
                end
                m_valid = 1;
                m_held  = 0;
            end
        end else begin
            m_to = 0;
            if (rel || !r[m_idx]) begin
                m_valid = 0;
                m_ptr   = (m_idx + 1) % 4;
            end else begin
                m_held++;
                if (TO_EN && m_held == TIMEOUT) begin
                    m_valid = 0;
                    m_to    = 1;
                    m_ptr   = (m_idx + 1) % 4;
                end
            end
        end
    endtask

    task automatic drive(input bit rst, input logic [3:0] r, input bit rel);
        reset = rst; req = r; gnt_release = rel;
        @(posedge clk);
        model_edge(rst, r, rel);
        #1;
    endtask

    task automatic test_reset();
        drive(1, 4'b1111, 1);
        drive(1, 4'b0000, 0);
        n_checks++; if (gnt_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", gnt_valid); end
        n_checks++; if (gnt_idx !== 2'd0) begin n_fail++; $display("FAIL reset_idx got=%0d exp=0", gnt_idx); end
        n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout got=%b exp=0", timeout); end
    endtask

    task automatic test_single();
        drive(0, 4'b0100, 0);
        n_checks++; if (gnt_valid !== 1'b1 || gnt_idx !== 2'd2) begin n_fail++; $display("FAIL single_grant got=%b/%0d exp=1/2", gnt_valid, gnt_idx); end
        drive(0, 4'b0100, 1);
        n_checks++; if (gnt_valid !== 1'b0 || gnt_idx !== 2'd2) begin n_fail++; $display("FAIL single_release got=%b/%0d exp=0/2", gnt_valid, gnt_idx); end
        drive(0, 4'b0000, 1);
        n_checks++; if (gnt_valid !== 1'b0) begin n_fail++; $display("FAIL idle_release_ignored got=%b exp=0", gnt_valid); end
    endtask

    task automatic test_wrap();
        drive(0, 4'b0011, 0);
        n_checks++; if (gnt_valid !== 1'b1 || gnt_idx !== 2'd0) begin n_fail++; $display("FAIL wrap_first got=%b/%0d exp=1/0", gnt_valid, gnt_idx); end
        drive(0, 4'b0011, 1);
        drive(0, 4'b0010, 0);
        n_checks++; if (gnt_valid !== 1'b1 || gnt_idx !== 2'd1) begin n_fail++; $display("FAIL wrap_second got=%b/%0d exp=1/1", gnt_valid, gnt_idx); end
        drive(0, 4'b0010, 1);
    endtask

    task automatic test_round_robin();
        drive(1, 4'b0000, 0);
        for (int k = 0; k < 5; k++) begin
            drive(0, 4'b1111, 0);
            n_checks++; if (gnt_valid !== 1'b1 || gnt_idx !== 2'(k % 4)) begin n_fail++; $display("FAIL rr_grant[%0d] got=%b/%0d exp=1/%0d", k, gnt_valid, gnt_idx, k % 4); end
            drive(0, 4'b1111, 1);
            n_checks++; if (gnt_valid !== 1'b0) begin n_fail++; $display("FAIL rr_gap[%0d] got=%b exp=0", k, gnt_valid); end
        end
    endtask

    task automatic test_drop();
        drive(1, 4'b0000, 0);
        drive(0, 4'b0010, 0);
        n_checks++; if (gnt_valid !== 1'b1 || gnt_idx !== 2'd1) begin n_fail++; $display("FAIL drop_grant got=%b/%0d exp=1/1", gnt_valid, gnt_idx); end
        drive(0, 4'b1101, 0);
        n_checks++; if (gnt_valid !== 1'b0) begin n_fail++; $display("FAIL drop_end got=%b exp=0", gnt_valid); end
        drive(0, 4'b1101, 0);
        n_checks++; if (gnt_valid !== 1'b1 || gnt_idx !== 2'd2) begin n_fail++; $display("FAIL drop_next got=%b/%0d exp=1/2", gnt_valid, gnt_idx); end
        drive(0, 4'b0111, 0);
        n_checks++; if (gnt_valid !== 1'b1 || gnt_idx !== 2'd2) begin n_fail++; $display("FAIL others_ignored got=%b/%0d exp=1/2", gnt_valid, gnt_idx); end
        drive(0, 4'b0100, 1);
    endtask

    task automatic test_reset_mid();
        drive(1, 4'b0000, 0);
        drive(0, 4'b1000, 0);
        n_checks++; if (gnt_valid !== 1'b1 || gnt_idx !== 2'd3) begin n_fail++; $display("FAIL mid_grant got=%b/%0d exp=1/3", gnt_valid, gnt_idx); end
        drive(1, 4'b1000, 0);
        n_checks++; if (gnt_valid !== 1'b0 || gnt_idx !== 2'd0 || timeout !== 1'b0) begin n_fail++; $display("FAIL mid_reset got=%b/%0d/%b exp=0/0/0", gnt_valid, gnt_idx, timeout); end
        drive(0, 4'b1000, 0);
        n_checks++; if (gnt_valid !== 1'b1 || gnt_idx !== 2'd3) begin n_fail++; $display("FAIL mid_regrant got=%b/%0d exp=1/3", gnt_valid, gnt_idx); end
        drive(0, 4'b1000, 1);
    endtask

    task automatic test_hold();
        drive(1, 4'b0000, 0);
        drive(0, 4'b0001, 0);
        for (int k = 1; k < TIMEOUT; k++) begin
            drive(0, 4'b0001, 0);
            n_checks++; if (gnt_valid !== 1'b1 || timeout !== 1'b0) begin n_fail++; $display("FAIL hold[%0d] got=%b/%b exp=1/0", k, gnt_valid, timeout); end
        end
        drive(0, 4'b0001, 0);
        if (TO_EN) begin
            n_checks++; if (gnt_valid !== 1'b0 || timeout !== 1'b1) begin n_fail++; $display("FAIL expire got=%b/%b exp=0/1", gnt_valid, timeout); end
            drive(0, 4'b0001, 0);
            n_checks++; if (gnt_valid !== 1'b1 || gnt_idx !== 2'd0 || timeout !== 1'b0) begin n_fail++; $display("FAIL after_expire got=%b/%0d/%b exp=1/0/0", gnt_valid, gnt_idx, timeout); end
            // Release on the expiry edge wins
            for (int k = 1; k < TIMEOUT; k++) drive(0, 4'b0001, 0);
            drive(0, 4'b0001, 1);
            n_checks++; if (gnt_valid !== 1'b0 || timeout !== 1'b0) begin n_fail++; $display("FAIL release_wins got=%b/%b exp=0/0", gnt_valid, timeout); end
        end else begin
            for (int k = 0; k < 12; k++) begin
                n_checks++; if (gnt_valid !== 1'b1 || timeout !== 1'b0) begin n_fail++; $display("FAIL no_timeout[%0d] got=%b/%b exp=1/0", k, gnt_valid, timeout); end
                drive(0, 4'b0001, 0);
            end
            drive(0, 4'b0001, 1);
        end
    endtask

    task automatic test_random();
        drive(1, 4'b0000, 0);
        for (int k = 0; k < 400; k++) begin
            drive(($urandom_range(0, 49) == 0), 4'($urandom), ($urandom_range(0, 3) == 0));
            n_checks++; if (gnt_valid !== m_valid) begin n_fail++; $display("FAIL rand_valid[%0d] got=%b exp=%b", k, gnt_valid, m_valid); end
            n_checks++; if (gnt_idx !== 2'(m_idx)) begin n_fail++; $display("FAIL rand_idx[%0d] got=%0d exp=%0d", k, gnt_idx, m_idx); end
            n_checks++; if (timeout !== m_to) begin n_fail++; $display("FAIL rand_timeout[%0d] got=%b exp=%b", k, timeout, m_to); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_wrap();
        test_round_robin();
        test_drop();
        test_reset_mid();
        test_hold();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rr_arbiter_4.md
RR_ARBITER_4 -- requirements
Module: rr_arbiter_4

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 8: maximum cycles a grant is held before forced release; legal range 2..255; used only when ARB_TIMEOUT_EN is defined.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port req, input, 4, request per requester 0..3; level-sensitive, held by the requester until served.
REQ-005 SHALL have port release, input, 1, one-cycle pulse from the current holder ending its grant.
REQ-006 SHALL have port gnt_valid, output, 1, high while a grant is active.
REQ-007 SHALL have port gnt_idx, output, 2, binary index of the granted requester; feeds the downstream 2-to-4 decoder.
REQ-008 SHALL have port timeout, output, 1, one-cycle pulse on forced release.

Function
REQ-009 SHALL implement a two-state FSM: IDLE and GRANT.
REQ-010 IDLE: if req != 0 at an edge, SHALL select the first set bit searching ptr, ptr+1, ... mod 4, and after that same edge drive gnt_valid=1 and gnt_idx=winner, entering GRANT (1-cycle latency from sampled req).
REQ-011 IDLE with req == 0: SHALL remain in IDLE, gnt_valid=0.
REQ-012 GRANT: SHALL hold gnt_idx constant and gnt_valid=1 while release=0 and req[gnt_idx]=1.
REQ-013 GRANT: on an edge with release=1 or req[gnt_idx]=0, SHALL drive gnt_valid=0, set ptr=gnt_idx+1 (mod 4, 3 wraps to 0), return to IDLE.
REQ-014 SHALL insert at least one IDLE cycle (gnt_valid=0) between consecutive grants.
REQ-015 gnt_idx SHALL retain its last value while gnt_valid=0.
REQ-016 release sampled in IDLE SHALL be ignored.
REQ-017 Requests from other requesters arriving or dropping during GRANT SHALL NOT affect the current grant.
REQ-018 With all four req bits held high, grants SHALL cycle 0,1,2,3,0,... (from ptr=0), no requester starved.

Reset
REQ-019 reset=1 at an edge SHALL force IDLE, gnt_valid=0, gnt_idx=2'b00, ptr=2'b00, timeout=0, hold counter=0, taking priority over all other inputs.
REQ-020 reset asserted during GRANT SHALL abort the grant without a timeout pulse; the first grant after reset deasserts follows REQ-010 with ptr=0.

Configuration
REQ-021 Macro ARB_TIMEOUT_EN SHALL compile in the hold-timeout feature.
REQ-022 Defined: a counter SHALL clear on GRANT entry and increment each GRANT cycle; if the grant reaches TIMEOUT_CYCLES cycles without release, at that edge SHALL drive gnt_valid=0, timeout=1 for one cycle, advance ptr per REQ-013, return to IDLE.
REQ-023 Defined: release=1 or req[gnt_idx]=0 on the same edge as expiry SHALL win; timeout stays 0.
REQ-024 Not defined: timeout SHALL be tied 0, no counter SHALL exist, grants last until release or request drop; TIMEOUT_CYCLES unused.

Verification
REQ-025 Reset, then req=4'b0100 -> one edge later gnt_valid=1, gnt_idx=2; release pulse -> gnt_valid=0 next cycle, ptr=3.
REQ-026 req=4'b1111 held, release pulsed each grant -> gnt_idx sequence 0,1,2,3,0 with one gnt_valid=0 cycle between grants.
REQ-027 ptr=3 (after serving 2), req=4'b0011 -> grant to 0 (wrap), then 1.
REQ-028 Grant to 1 active, req changes to 4'b1101 (bit1 drops) -> gnt_valid=0 next cycle, next grant to 2.
REQ-029 ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, req=4'b0001, no release -> gnt_valid high exactly 8 cycles, then timeout=1 one cycle, re-grant to 0 after one IDLE cycle; release on the expiry edge -> timeout=0.
REQ-030 reset pulsed mid-GRANT with gnt_idx=3 -> gnt_valid=0, gnt_idx=0, timeout=0 next cycle; then req=4'b1000 -> grant to 3.
